// File: rtl/note_sequencer.sv
// Melody sequencer feeding the square-wave tone generator: walks a host-written note
// table and presents one half-period per note for its duration. Optional SEQ_LOOP_EN loops the song.
module note_sequencer #(
  parameter int CLOCK_FREQUENCY = 12000000,
  parameter int TICK_HZ         = 100,
  parameter int SONG_LEN        = 16,
  parameter int GAP_TICKS       = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        wr_en,
  input  logic [$clog2(SONG_LEN)-1:0] wr_addr,
  input  logic [23:0]                 wr_data,
  output logic [15:0]                 half_period,
  output logic                        gate,
  output logic                        note_strobe,
  output logic                        busy,
  output logic                        done
);

  localparam int DIV   = CLOCK_FREQUENCY / TICK_HZ;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW    = $clog2(SONG_LEN);
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [AW-1:0]    ADDR_LAST = AW'(SONG_LEN - 1);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, PLAY, GAP} state_t;

  state_t             state, state_nxt;
  logic [23:0]        mem [SONG_LEN];
  logic [23:0]        rd_data;
  logic [AW-1:0]      addr;
  logic [DIV_W-1:0]   div;
  logic [GAP_W-1:0]   gap_cnt;
  logic [7:0]         rem;
  logic [15:0]        hp_q;
  logic               gate_q;
  logic               tick, dec_note, mark;
  logic               load, to_idle, to_gap, addr_inc, addr_zero, done_c, div_clr, adv;
  logic [15:0]        rd_hp;
  logic [7:0]         rd_dur;

  assign rd_hp    = rd_data[23:8];
  assign rd_dur   = rd_data[7:0];
  assign tick     = (div == DIV_LAST);
  assign dec_note = (state == DECODE) && (rd_dur != 8'd0);
  assign mark     = (state == DECODE) && (rd_dur == 8'd0);

  // New note is shown straight from the read register so it appears two cycles after start.
  assign half_period = dec_note ? rd_hp : hp_q;
  assign gate        = (state == DECODE) ? (dec_note && (rd_hp != 16'd0)) : gate_q;
  assign note_strobe = dec_note;
  assign done        = done_c;
  assign busy        = (state != IDLE);

  // Table RAM: no reset, read-before-write on a same-cycle collision.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (state == FETCH) rd_data <= mem[addr];
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    to_idle   = 1'b0;
    to_gap    = 1'b0;
    addr_inc  = 1'b0;
    addr_zero = 1'b0;
    done_c    = 1'b0;
    div_clr   = 1'b0;
    adv       = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = FETCH;
        addr_zero = 1'b1;
        div_clr   = 1'b1;
      end
      FETCH: state_nxt = DECODE;
      DECODE: if (rd_dur == 8'd0) begin
`ifdef SEQ_LOOP_EN
        // An end marker at entry 0 would loop silently forever, so it still ends playback.
        if (addr != '0) begin
          addr_zero = 1'b1;
          state_nxt = FETCH;
        end else begin
          done_c  = 1'b1;
          to_idle = 1'b1;
        end
`else
        done_c  = 1'b1;
        to_idle = 1'b1;
`endif
      end else begin
        load      = 1'b1;
        div_clr   = 1'b1;
        state_nxt = PLAY;
      end
      PLAY: if (tick && rem == 8'd1) begin
        if (GAP_TICKS > 0) begin
          to_gap    = 1'b1;
          state_nxt = GAP;
        end else begin
          adv = 1'b1;
        end
      end
      GAP: if (tick && gap_cnt == GAP_LAST) adv = 1'b1;
      default: state_nxt = IDLE;
    endcase
    if (adv) begin
      if (addr == ADDR_LAST) begin
`ifdef SEQ_LOOP_EN
        addr_zero = 1'b1;
        state_nxt = FETCH;
`else
        done_c  = 1'b1;
        to_idle = 1'b1;
`endif
      end else begin
        addr_inc  = 1'b1;
        state_nxt = FETCH;
      end
    end
    if (to_idle) state_nxt = IDLE;
    if (stop) begin
      state_nxt = IDLE;
      to_idle   = 1'b1;
      done_c    = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      div     <= '0;
      addr    <= '0;
      gap_cnt <= '0;
      rem     <= '0;
      hp_q    <= '0;
      gate_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (div_clr || tick) div <= '0;
      else                 div <= div + 1'b1;
      if (addr_zero)     addr <= '0;
      else if (addr_inc) addr <= addr + 1'b1;
      if (load) begin
        hp_q   <= rd_hp;
        gate_q <= (rd_hp != 16'd0);
        rem    <= rd_dur;
      end else if (state == PLAY && tick) begin
        rem <= rem - 8'd1;
      end
      if (to_gap) begin
        gate_q  <= 1'b0;
        gap_cnt <= '0;
      end else if (state == GAP && tick) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
      if (mark) gate_q <= 1'b0;
      if (to_idle) begin
        hp_q   <= '0;
        gate_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: expected strobe/done events are queued at start
// and matched when the DUT emits them. A second GAP_TICKS=0 instance covers legato.
module tb_note_sequencer;

  localparam int LEN = 4;
  localparam int GAP = 1;

  logic        clock = 1'b0;
  logic        reset, start, stop, start0, stop0, wr_en;
  logic [1:0]  wr_addr;
  logic [23:0] wr_data;
  logic [15:0] half_period, half_period0;
  logic        gate, note_strobe, busy, done;
  logic        gate0, note_strobe0, busy0, done0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          t;
    logic        kind;
    logic [15:0] hp;
    logic        g;
  } ev_t;
  ev_t sb[$];

  logic [15:0] tb_hp  [LEN];
  logic [7:0]  tb_dur [LEN];

  note_sequencer #(.CLOCK_FREQUENCY(1000), .TICK_HZ(100), .SONG_LEN(LEN), .GAP_TICKS(GAP)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .half_period(half_period), .gate(gate),
    .note_strobe(note_strobe), .busy(busy), .done(done));

  note_sequencer #(.CLOCK_FREQUENCY(1000), .TICK_HZ(100), .SONG_LEN(LEN), .GAP_TICKS(0)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .stop(stop0), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .half_period(half_period0), .gate(gate0),
    .note_strobe(note_strobe0), .busy(busy0), .done(done0));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && (note_strobe || done)) begin
      if (sb.size() == 0) begin
        chk("unexp_evt", {30'd0, note_strobe, done}, 32'd0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        chk("evt_cyc", cyc, e.t);
        chk("evt_done", {31'd0, done}, {31'd0, e.kind});
        if (!e.kind) begin
          chk("evt_hp", {16'd0, half_period}, {16'd0, e.hp});
          chk("evt_gate", {31'd0, gate}, {31'd0, e.g});
        end
      end
    end
  end

  // Expected timing: a note strobed at t with duration d ends its gap at t+10d+10*GAP,
  // the next entry strobes two cycles later (FETCH, DECODE).
  function automatic void push_song(int n, int nmax);
    int t = n + 2;
    int i = 0;
    int k = 0;
    while (k < nmax) begin
      if (tb_dur[i] == 8'd0) begin
`ifdef SEQ_LOOP_EN
        if (i != 0) begin
          i = 0;
          t = t + 2;
          continue;
        end
`endif
        sb.push_back('{t, 1'b1, 16'd0, 1'b0});
        return;
      end
      sb.push_back('{t, 1'b0, tb_hp[i], tb_hp[i] != 16'd0});
      k++;
      t = t + 10 * int'(tb_dur[i]) + 10 * GAP;
      if (i == LEN - 1) begin
`ifdef SEQ_LOOP_EN
        i = 0;
        t = t + 2;
`else
        sb.push_back('{t, 1'b1, 16'd0, 1'b0});
        return;
`endif
      end else begin
        i++;
        t = t + 2;
      end
    end
  endfunction

  task automatic wr(input int a, input logic [15:0] hp, input logic [7:0] d);
    @(posedge clock); #1;
    wr_en = 1'b1; wr_addr = 2'(a); wr_data = {hp, d};
    tb_hp[a] = hp; tb_dur[a] = d;
    @(posedge clock); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic start_pulse(output int n, input int nmax);
    @(posedge clock); #1;
    start = 1'b1;
    n = cyc;
    push_song(n, nmax);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic stop_pulse();
    @(posedge clock); #1;
    stop = 1'b1;
    sb.delete();
    @(posedge clock); #1;
    stop = 1'b0;
  endtask

  task automatic wait_sb(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    chk("sb_drain", sb.size(), 0);
  endtask

  task automatic finish_song();
    wait_sb(500);
`ifdef SEQ_LOOP_EN
    stop_pulse();
`endif
    chk("busy_end", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < LEN; i++) begin
      tb_hp[i] = '0; tb_dur[i] = '0;
    end
    reset = 1'b1; start = 1'b0; stop = 1'b0; start0 = 1'b0; stop0 = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_hp", {16'd0, half_period}, 32'd0);
    chk("rst_outs", {28'd0, gate, note_strobe, busy, done}, 32'd0);
    reset = 1'b0;

    // 1: tone, rest, end marker
    wr(0, 16'h0017, 8'd2);
    wr(1, 16'h0000, 8'd1);
    wr(2, 16'hABCD, 8'd0);
    start_pulse(n, 3);
    wait_cyc(n + 22);
    chk("t1_gate_last", {31'd0, gate}, 32'd1);
    wait_cyc(n + 23);
    chk("t1_gate_gap", {31'd0, gate}, 32'd0);
    chk("t1_hp_gap", {16'd0, half_period}, 32'h17);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    finish_song();

    // 2: stop mid-note, then full replay
    start_pulse(n, 3);
    wait_cyc(n + 10);
    stop_pulse();
    chk("t2_stop_hp", {16'd0, half_period}, 32'd0);
    chk("t2_stop_outs", {30'd0, gate, busy}, 32'd0);
    repeat (40) @(posedge clock);
    #1;
    start_pulse(n, 3);
    finish_song();

    // 3: start+stop together in IDLE; start while busy ignored
    @(posedge clock); #1;
    start = 1'b1; stop = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; stop = 1'b0;
    chk("t3_busy", {31'd0, busy}, 32'd0);
    repeat (5) @(posedge clock);
    #1;
    chk("t3_idle", {30'd0, note_strobe, done}, 32'd0);
    start_pulse(n, 3);
    wait_cyc(n + 8);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    finish_song();

    // 4: every entry has duration 1; end of table ends (or loops)
    for (int i = 0; i < LEN; i++) wr(i, 16'(16'h0100 + i), 8'd1);
    start_pulse(n, LEN + 1);
    finish_song();

    // 5: asynchronous reset mid-note; table survives
    start_pulse(n, LEN + 1);
    wait_cyc(n + 6);
    reset = 1'b1;
    sb.delete();
    #1;
    chk("t5_rst_hp", {16'd0, half_period}, 32'd0);
    chk("t5_rst_outs", {28'd0, gate, note_strobe, busy, done}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    start_pulse(n, LEN + 1);
    finish_song();

    // 6: legato instance, gate holds across notes
    wr(0, 16'h0010, 8'd1);
    wr(1, 16'h0020, 8'd2);
    wr(2, 16'h0000, 8'd0);
    @(posedge clock); #1;
    start0 = 1'b1;
    n = cyc;
    @(posedge clock); #1;
    start0 = 1'b0;
    for (int k = 1; k <= 37; k++) begin
      wait_cyc(n + k);
      chk("t6_strobe", {31'd0, note_strobe0}, {31'd0, (k == 2 || k == 14)});
      chk("t6_gate", {31'd0, gate0}, {31'd0, (k >= 2 && k <= 35)});
`ifdef SEQ_LOOP_EN
      chk("t6_done", {31'd0, done0}, 32'd0);
`else
      chk("t6_done", {31'd0, done0}, {31'd0, (k == 36)});
`endif
      if (k == 14) chk("t6_hp", {16'd0, half_period0}, 32'h20);
    end
    @(posedge clock); #1;
    stop0 = 1'b1;
    @(posedge clock); #1;
    stop0 = 1'b0;
    chk("t6_busy", {31'd0, busy0}, 32'd0);

    chk("sb_final", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
